// File: rtl/dcache_controller.sv
// Controller for a 2-way set-associative L1 data cache. It serves CPU hits from SRAM, and on a miss it writes back a dirty victim, refills the line, then retries.
// Optional hit/miss performance counters are compiled in when DCACHE_PERF_EN is defined.
module dcache_controller #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [3:0]        sram_addr_o,
  output logic [24:0]       sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [24:0]       sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;

  state_t state_q, state_d;

  logic [22:0]       cpu_tag;
  logic [3:0]        index;
  logic [2:0]        word_sel;
  logic              req_hit;
  logic              req_miss;
  logic              victim_dirty;
  logic              issue_wb;
  logic              issue_rd;
  logic [LINE_W-1:0] store_line;

  logic              mem_enable_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_data_q;

  assign cpu_tag      = cpu_addr_i[31:9];
  assign index        = cpu_addr_i[8:5];
  assign word_sel     = cpu_addr_i[4:2];
  assign req_hit      = (state_q == IDLE) & cpu_req_i & sram_hit_i;
  assign req_miss     = (state_q == IDLE) & cpu_req_i & ~sram_hit_i;
  assign victim_dirty = sram_tag_i[24] & sram_tag_i[23];

  assign sram_addr_o  = index;
  assign cpu_data_o   = sram_data_i[{word_sel, 5'b0} +: 32];
  assign cpu_stall_o  = (state_q != IDLE) | (cpu_req_i & ~sram_hit_i);

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_comb begin
    store_line = sram_data_i;
    store_line[{word_sel, 5'b0} +: 32] = cpu_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    sram_enable_o = 1'b0;
    sram_write_o  = 1'b0;
    sram_tag_o    = {2'b00, cpu_tag};
    sram_data_o   = sram_data_i;
    issue_wb      = 1'b0;
    issue_rd      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hit && cpu_write_i) begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = {2'b11, cpu_tag};
          sram_data_o   = store_line;
        end else if (req_miss) begin
          state_d = MISS;
        end
      end
      MISS: begin
        if (victim_dirty) begin
          issue_wb = 1'b1;
          state_d  = WRITEBACK;
        end else begin
          issue_rd = 1'b1;
          state_d  = READMISS;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          issue_rd = 1'b1;
          state_d  = READMISS;
        end
      end
      READMISS: begin
        // Refill lands in the SRAM the same cycle the memory acknowledges it.
        if (mem_ack_i) begin
          sram_enable_o = 1'b1;
          sram_write_o  = 1'b1;
          sram_tag_o    = {2'b10, cpu_tag};
          sram_data_o   = mem_data_i;
          state_d       = READMISSOK;
        end
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Memory request registers stay stable from the enable pulse until the ack.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      mem_enable_q <= issue_wb | issue_rd;
      if (issue_wb) begin
        mem_write_q <= 1'b1;
        mem_addr_q  <= {sram_tag_i[22:0], index, 5'b0};
        mem_data_q  <= sram_data_i;
      end else if (issue_rd) begin
        mem_write_q <= 1'b0;
        mem_addr_q  <= {cpu_tag, index, 5'b0};
      end
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (req_hit && hit_cnt_q != 32'hFFFF_FFFF)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (req_miss && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with behavioural 2-way LRU SRAM and latency-configurable main memory.
// Load data and memory requests are checked against scoreboard queues.
module tb_dcache_controller;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic        chk;
    logic [2:0]  w;
    logic [31:0] word;
  } mem_req_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_PERF_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int compared   = 0;
  int mismatched = 0;
  int mem_latency = 10;
  bit expect_abort = 1'b0;

  logic [31:0] load_q [$];
  mem_req_t    exp_mem_q [$];

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_PERF_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] pattern(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = a + 32'(i);
    return l;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural SRAM: two ways per set, lookup is combinational, LRU bit names the victim.
  bit          sv_v   [16][2];
  bit          sv_d   [16][2];
  bit [22:0]   sv_tag [16][2];
  bit [255:0]  sv_dat [16][2];
  bit          sv_lru [16];
  logic        hit_way;
  logic        sel_way;

  always_comb begin
    sram_hit_i = 1'b0;
    hit_way    = 1'b0;
    if (sv_v[sram_addr_o][0] && sv_tag[sram_addr_o][0] == sram_tag_o[22:0]) begin
      sram_hit_i = 1'b1;
      hit_way    = 1'b0;
    end else if (sv_v[sram_addr_o][1] && sv_tag[sram_addr_o][1] == sram_tag_o[22:0]) begin
      sram_hit_i = 1'b1;
      hit_way    = 1'b1;
    end
    sel_way     = sram_hit_i ? hit_way : sv_lru[sram_addr_o];
    sram_tag_i  = {sv_v[sram_addr_o][sel_way], sv_d[sram_addr_o][sel_way], sv_tag[sram_addr_o][sel_way]};
    sram_data_i = sv_dat[sram_addr_o][sel_way];
  end

  always @(posedge clk_i) begin
    if (sram_enable_o && sram_write_o) begin
      sv_v[sram_addr_o][sel_way]   <= sram_tag_o[24];
      sv_d[sram_addr_o][sel_way]   <= sram_tag_o[23];
      sv_tag[sram_addr_o][sel_way] <= sram_tag_o[22:0];
      sv_dat[sram_addr_o][sel_way] <= sram_data_o;
      sv_lru[sram_addr_o]          <= ~sel_way;
    end else if (cpu_req_i && sram_hit_i) begin
      sv_lru[sram_addr_o] <= ~hit_way;
    end
  end

  // Main memory: accepts a request pulse, acks mem_latency cycles later.
  initial begin : mem_model
    logic [255:0] mem [logic [31:0]];
    logic [255:0] line;
    logic [255:0] wd;
    logic [31:0]  a;
    logic         w;
    mem_req_t     e;
    line = pattern(32'h40);
    line[31:0]  = 32'hDEAD_BEEF;
    line[63:32] = 32'hDEAD_BEEF;
    mem[32'h40] = line;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (rst_i && mem_enable_o) begin
        a  = mem_addr_o;
        w  = mem_write_o;
        wd = mem_data_o;
        if (exp_mem_q.size() == 0) begin
          checkOutput("mem_unexpected_req", 64'(a), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_mem_q.pop_front();
          checkOutput("mem_write", 64'(w), 64'(e.wr));
          checkOutput("mem_addr", 64'(a), 64'(e.addr));
          if (e.chk) checkOutput("mem_wb_word", 64'(wd[{e.w, 5'b0} +: 32]), 64'(e.word));
        end
        if (mem_latency > 0) begin
          repeat (mem_latency) @(posedge clk_i);
          #1;
        end
        if (!expect_abort) checkOutput("mem_addr_hold", 64'(mem_addr_o), 64'(a));
        if (w) mem[a] = wd;
        else   mem_data_i = mem.exists(a) ? mem[a] : pattern(a);
        mem_ack_i = 1'b1;
      end
    end
  end

  task automatic expectMem(input logic wr, input logic [31:0] addr, input logic chk,
                           input logic [2:0] w, input logic [31:0] word);
    mem_req_t e;
    e.wr = wr; e.addr = addr; e.chk = chk; e.w = w; e.word = word;
    exp_mem_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_load, output int stalls);
    bit done;
    @(posedge clk_i); #1;
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    if (!wr) load_q.push_back(exp_load);
    stalls = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      if (!cpu_stall_o) done = 1'b1;
      else begin
        stalls++;
        if (stalls > 300) begin
          checkOutput("stall_timeout", 64'(stalls), 64'd0);
          done = 1'b1;
        end
      end
    end
    if (!wr) begin
      if (load_q.size() != 0) checkOutput("load_data", 64'(cpu_data_o), 64'(load_q.pop_front()));
    end else begin
      checkOutput("store_strobe", 64'({sram_enable_o, sram_write_o}), 64'd3);
      checkOutput("store_vd_bits", 64'(sram_tag_o[24:23]), 64'd3);
    end
    @(posedge clk_i); #1;
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int  stalls;
    int  n;
    bit  seen;
    rst_i       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'b0;
    cpu_addr_i  = '0;
    cpu_data_i  = '0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_mem_enable", 64'(mem_enable_o), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("rst_sram_strobe", 64'({sram_enable_o, sram_write_o}), 64'd0);
    checkOutput("rst_stall", 64'(cpu_stall_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    $display("[TB] cold load miss, L=10");
    mem_latency = 10;
    expectMem(1'b0, 32'h40, 1'b0, 3'd0, 32'd0);
    applyStimulus(1'b0, 32'h40, 32'd0, 32'hDEAD_BEEF, stalls);
    checkOutput("cold_stall", 64'(stalls), 64'd14);

    $display("[TB] store hit then reload");
    applyStimulus(1'b1, 32'h44, 32'h1234_5678, 32'd0, stalls);
    checkOutput("store_stall", 64'(stalls), 64'd0);
    applyStimulus(1'b0, 32'h44, 32'd0, 32'h1234_5678, stalls);
    checkOutput("reload_stall", 64'(stalls), 64'd0);

    $display("[TB] dirty eviction in set 2");
    expectMem(1'b0, 32'h240, 1'b0, 3'd0, 32'd0);
    applyStimulus(1'b0, 32'h240, 32'd0, 32'h240, stalls);
    checkOutput("set2_fill_stall", 64'(stalls), 64'd14);
    expectMem(1'b1, 32'h40, 1'b1, 3'd1, 32'h1234_5678);
    expectMem(1'b0, 32'h440, 1'b0, 3'd0, 32'd0);
    applyStimulus(1'b0, 32'h440, 32'd0, 32'h440, stalls);
    checkOutput("dirty_miss_stall", 64'(stalls), 64'd25);

    $display("[TB] zero-latency refill");
    mem_latency = 0;
    expectMem(1'b0, 32'h80, 1'b0, 3'd0, 32'd0);
    applyStimulus(1'b0, 32'h8C, 32'd0, 32'h83, stalls);
    checkOutput("l0_stall", 64'(stalls), 64'd4);

    $display("[TB] reset during refill");
    mem_latency = 10;
    expectMem(1'b0, 32'hA0, 1'b0, 3'd0, 32'd0);
    @(posedge clk_i); #1;
    cpu_req_i  = 1'b1;
    cpu_addr_i = 32'hA4;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      @(negedge clk_i);
      if (mem_enable_o) seen = 1'b1;
      n++;
    end
    checkOutput("abort_pulse_seen", 64'(seen), 64'd1);
    @(posedge clk_i); #1;
    expect_abort = 1'b1;
    rst_i        = 1'b0;
    cpu_req_i    = 1'b0;
    @(negedge clk_i);
    checkOutput("midrst_mem_enable", 64'(mem_enable_o), 64'd0);
    checkOutput("midrst_mem_write", 64'(mem_write_o), 64'd0);
    checkOutput("midrst_mem_addr", 64'(mem_addr_o), 64'd0);
    checkOutput("midrst_mem_data", mem_data_o[63:0], 64'd0);
    checkOutput("midrst_stall", 64'(cpu_stall_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 30) begin
      @(negedge clk_i);
      if (mem_ack_i) seen = 1'b1;
      n++;
    end
    checkOutput("late_ack_seen", 64'(seen), 64'd1);
    checkOutput("late_ack_no_write", 64'(sram_enable_o), 64'd0);
    checkOutput("late_ack_no_stall", 64'(cpu_stall_o), 64'd0);
    @(posedge clk_i); #1;
    expect_abort = 1'b0;
    expectMem(1'b0, 32'hA0, 1'b0, 3'd0, 32'd0);
    applyStimulus(1'b0, 32'hA4, 32'd0, 32'hA1, stalls);
    checkOutput("post_rst_stall", 64'(stalls), 64'd14);

    $display("[TB] hits and a final miss for counters");
    applyStimulus(1'b1, 32'hA8, 32'hCAFE_F00D, 32'd0, stalls);
    applyStimulus(1'b0, 32'hA8, 32'd0, 32'hCAFE_F00D, stalls);
    applyStimulus(1'b0, 32'hA4, 32'd0, 32'hA1, stalls);
    checkOutput("hit_stall", 64'(stalls), 64'd0);
    expectMem(1'b0, 32'hC0, 1'b0, 3'd0, 32'd0);
    applyStimulus(1'b0, 32'hC0, 32'd0, 32'hC0, stalls);
    checkOutput("last_miss_stall", 64'(stalls), 64'd14);
`ifdef DCACHE_PERF_EN
    @(negedge clk_i);
    checkOutput("hit_cnt", 64'(hit_cnt_o), 64'd5);
    checkOutput("miss_cnt", 64'(miss_cnt_o), 64'd2);
`endif

    repeat (2) @(posedge clk_i);
    checkOutput("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    checkOutput("load_q_drained", 64'(load_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
